// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared LEGv8 constants, data-memory FSM states and helpers
package legv8_pkg;

  // Data-memory controller FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  // Load/store opcodes, shared with the core decoder
  localparam logic [10:0] OPC_LDR = 11'b11111000010;
  localparam logic [10:0] OPC_STR = 11'b11111000000;

  // Doublewords are aligned on 8-byte boundaries
  localparam int DW_ALIGN_BITS = 3;

  function automatic logic dw_misaligned(input logic [63:0] addr);
    return addr[DW_ALIGN_BITS-1:0] != '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous 64-bit RAM with registered read
module dmem_array #(
  parameter int IDX_WIDTH = 5
) (
  input  logic                 CLOCK,
  input  logic                 we,
  input  logic [IDX_WIDTH-1:0] index,
  input  logic [63:0]          wdata,
  output logic [63:0]          rdata
);

  logic [63:0] mem [0:(1<<IDX_WIDTH)-1];

  // Write on enable; read the addressed word every cycle (old data on a write)
  always_ff @(posedge CLOCK) begin
    if (we) begin
      mem[index] <= wdata;
    end
    rdata <= mem[index];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - LEGv8 data-memory responder with wait states and fault reporting
module data_mem_ctrl
  import legv8_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        MEMREAD,
  input  logic        MEMWRITE,
  input  logic [63:0] ADDRESS,
  input  logic [63:0] WRITE_DATA,
  output logic [63:0] READ_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR
);

  localparam int IDX_W = ADDR_WIDTH - DW_ALIGN_BITS;

  dmem_state_t      state, state_next;
  logic [3:0]       count_q;
  logic [IDX_W-1:0] idx_q;
  logic [63:0]      wdata_q;
  logic             rd_q;
  logic             wr_q;
  logic             fault_q;
  logic [63:0]      read_data_q;

  logic             request;
  logic             fault_now;
  logic             access;
  logic             ram_we;
  logic [IDX_W-1:0] ram_index;
  logic [63:0]      ram_rdata;

  assign request   = MEMREAD | MEMWRITE;
  assign fault_now = dw_misaligned(ADDRESS)
                   | (|ADDRESS[63:ADDR_WIDTH])
                   | (MEMREAD & MEMWRITE);
  assign access    = (state == ST_WAIT) && (count_q == 4'd0);
  assign ram_we    = access && wr_q && !fault_q;

  // In IDLE the RAM looks at the incoming address so the word is already
  // registered by the access edge, even with zero wait states.
  assign ram_index = (state == ST_IDLE) ? ADDRESS[ADDR_WIDTH-1:DW_ALIGN_BITS] : idx_q;

  dmem_array #(
    .IDX_WIDTH(IDX_W)
  ) u_array (
    .CLOCK(CLOCK),
    .we   (ram_we),
    .index(ram_index),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // FSM state register
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    ERROR      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (request) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        BUSY = 1'b1;
        if (count_q == 4'd0) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        DONE       = 1'b1;
        ERROR      = fault_q;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request latch, wait counter and load result register
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      count_q     <= 4'd0;
      idx_q       <= '0;
      wdata_q     <= 64'd0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      fault_q     <= 1'b0;
      read_data_q <= 64'd0;
    end else begin
      if ((state == ST_IDLE) && request) begin
        count_q <= 4'(WAIT_STATES);
        idx_q   <= ADDRESS[ADDR_WIDTH-1:DW_ALIGN_BITS];
        wdata_q <= WRITE_DATA;
        rd_q    <= MEMREAD;
        wr_q    <= MEMWRITE;
        fault_q <= fault_now;
      end else if (state == ST_WAIT) begin
        if (count_q != 4'd0) begin
          count_q <= count_q - 4'd1;
        end else if (rd_q && !fault_q) begin
          read_data_q <= ram_rdata;
        end
      end
    end
  end

  assign READ_DATA = read_data_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst   [2];
  logic        mr    [2];
  logic        mw    [2];
  logic [63:0] ad    [2];
  logic [63:0] wd    [2];
  logic [63:0] rdat  [2];
  logic        busy  [2];
  logic        done  [2];
  logic        err   [2];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          ws    [2];

  logic [63:0] mem   [2][32];
  logic [63:0] rdm   [2];

  data_mem_ctrl #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut_ws2 (
    .CLOCK(clk), .RESET(rst[0]), .MEMREAD(mr[0]), .MEMWRITE(mw[0]),
    .ADDRESS(ad[0]), .WRITE_DATA(wd[0]), .READ_DATA(rdat[0]),
    .BUSY(busy[0]), .DONE(done[0]), .ERROR(err[0])
  );

  data_mem_ctrl #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut_ws0 (
    .CLOCK(clk), .RESET(rst[1]), .MEMREAD(mr[1]), .MEMWRITE(mw[1]),
    .ADDRESS(ad[1]), .WRITE_DATA(wd[1]), .READ_DATA(rdat[1]),
    .BUSY(busy[1]), .DONE(done[1]), .ERROR(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete request on unit u, checked against the reference model
  task automatic req(input int u, input logic rd, input logic wr,
                     input logic [63:0] a, input logic [63:0] d);
    logic exp_err;
    int   idx;
    int   n;
    int   nbusy;
    bit   seen;
    exp_err = (a[2:0] != 3'd0) || (a[63:8] != 56'd0) || (rd && wr);
    idx     = int'(a[7:3]);
    @(negedge clk);
    mr[u] = rd; mw[u] = wr; ad[u] = a; wd[u] = d;
    @(posedge clk); #1;
    mr[u] = 1'b0; mw[u] = 1'b0;
    n = 0; nbusy = 0; seen = 0;
    while (!seen && n <= 40) begin
      if (done[u] === 1'b1) begin
        seen = 1;
      end else begin
        if (busy[u] === 1'b1) nbusy++;
        @(posedge clk); #1;
        n++;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      if (!exp_err) begin
        if (wr) mem[u][idx] = d;
        if (rd) rdm[u] = mem[u][idx];
      end
      chk("latency", 64'(n), 64'(ws[u] + 1));
      chk("busy_cycles", 64'(nbusy), 64'(ws[u] + 1));
      chk("error", 64'(err[u]), 64'(exp_err));
      chk("read_data", rdat[u], rdm[u]);
      @(posedge clk); #1;
      chk("done_pulse_end", 64'(done[u]), 64'd0);
      chk("busy_after", 64'(busy[u]), 64'd0);
    end
  endtask

  initial begin
    int          t0;
    int          t1;
    int          got;
    int          n;
    int          u;
    int          r;
    int          op;
    logic [63:0] a;

    ws[0] = 2; ws[1] = 0;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; mr[k] = 1'b0; mw[k] = 1'b0; ad[k] = 64'd0; wd[k] = 64'd0;
      rdm[k] = 64'd0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", 64'(busy[k]), 64'd0);
      chk("rst_done", 64'(done[k]), 64'd0);
      chk("rst_error", 64'(err[k]), 64'd0);
      chk("rst_read_data", rdat[k], 64'd0);
    end
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Give every RAM location a known value
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        req(k, 1'b0, 1'b1, 64'(i) << 3, {$urandom, $urandom});
      end
    end

    // Store then load at 0x10
    req(0, 1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567);
    req(0, 1'b1, 1'b0, 64'h10, 64'd0);
    chk("load_0x10", rdat[0], 64'hDEAD_BEEF_0123_4567);

    // Misaligned load keeps previous READ_DATA
    req(0, 1'b1, 1'b0, 64'h0C, 64'd0);

    // Out-of-range store, then full readback
    req(0, 1'b0, 1'b1, 64'h100, 64'hFFFF_0000_FFFF_0000);
    for (int i = 0; i < 32; i++) begin
      req(0, 1'b1, 1'b0, 64'(i) << 3, 64'd0);
    end

    // Conflicting request at 0x08, RAM[1] must be intact
    req(0, 1'b1, 1'b1, 64'h08, 64'h1234_5678_9ABC_DEF0);
    req(0, 1'b1, 1'b0, 64'h08, 64'd0);

    // Reset during WAIT aborts the store to 0x18
    @(negedge clk);
    mw[0] = 1'b1; ad[0] = 64'h18; wd[0] = 64'hA5A5_A5A5_5A5A_5A5A;
    @(posedge clk); #1;
    mw[0] = 1'b0;
    chk("abort_busy_before", 64'(busy[0]), 64'd1);
    rst[0] = 1'b1;
    #1;
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_done", 64'(done[0]), 64'd0);
    chk("abort_error", 64'(err[0]), 64'd0);
    chk("abort_read_data", rdat[0], 64'd0);
    rdm[0] = 64'd0;
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 64'(done[0]), 64'd0);
    end
    req(0, 1'b1, 1'b0, 64'h18, 64'd0);

    // Zero wait states, request held high across two loads
    @(negedge clk);
    mr[1] = 1'b1; ad[1] = 64'h00;
    got = 0; n = 0; t0 = 0; t1 = 0;
    while (got < 2 && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (done[1] === 1'b1) begin
        chk("b2b_error", 64'(err[1]), 64'd0);
        if (got == 0) begin
          chk("b2b_data0", rdat[1], mem[1][0]);
          t0 = cyc;
          ad[1] = 64'h08;
        end else begin
          chk("b2b_data1", rdat[1], mem[1][1]);
          t1 = cyc;
          mr[1] = 1'b0;
        end
        got++;
      end
    end
    mr[1] = 1'b0;
    chk("b2b_count", 64'(got), 64'd2);
    chk("b2b_spacing", 64'(t1 - t0), 64'd3);
    rdm[1] = mem[1][1];
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_no_third", 64'(busy[1]), 64'd0);

    // Randomised mix on both units
    for (int i = 0; i < 60; i++) begin
      u  = int'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 7));
      op = int'($urandom_range(0, 1));
      a  = 64'($urandom_range(0, 31)) << 3;
      if (r == 0) a = a | 64'($urandom_range(1, 7));
      if (r == 1) a = a | (64'd1 << $urandom_range(8, 63));
      req(u, (op == 0) || (r == 2), (op == 1) || (r == 2), a, {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
